// File: rtl/calc_acc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_acc_seq_if
// Description : Operand/command and result bundle between the switch/button
//               front end (master) and the accumulator calculator (slave).
//               master drives : button, func, num1, num2
//               slave drives  : cal_result, busy, done, ovf, err_div0
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_acc_seq_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
);
    logic              button;
    logic [2:0]        func;
    logic [DATA_W-1:0] num1;
    logic [DATA_W-1:0] num2;
    logic [ACC_W-1:0]  cal_result;
    logic              busy;
    logic              done;
    logic              ovf;
    logic              err_div0;

    modport master (
        output button, func, num1, num2,
        input  cal_result, busy, done, ovf, err_div0
    );

    modport slave (
        input  button, func, num1, num2,
        output cal_result, busy, done, ovf, err_div0
    );
endinterface
`default_nettype wire

// File: rtl/calc_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : calc_acc_seq
// Description : Unsigned accumulator calculator. ADD/SUB/CLEAR/NO-OP finish
//               in the start cycle; MUL/SQUARE/DIV/MOD share one iterative
//               shift datapath (ACC_W steps) with busy/done handshake.
// Ports       : clk_g  - system clock (rising edge)
//               rst_n  - asynchronous active-low reset
//               bus    - calc_acc_seq_if.slave (button, func, num1, num2 in;
//                        cal_result, busy, done, ovf, err_div0 out)
// Revision    : 1.0 - initial release
// ============================================================================
module calc_acc_seq #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  wire logic     clk_g,
    input  wire logic     rst_n,
    calc_acc_seq_if.slave bus
);
    localparam int CNT_W = $clog2(ACC_W + 1);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_DIV = 3'b011;
    localparam logic [2:0] c_OP_MOD = 3'b100;
    localparam logic [2:0] c_OP_SQR = 3'b101;
    localparam logic [2:0] c_OP_CLR = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ITER   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_MUL = 2'd0,
        K_DIV = 2'd1,
        K_MOD = 2'd2
    } kind_t;

    state_t             r_state;
    kind_t              r_kind;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*ACC_W-1:0] r_pq;     // product (MUL) or {remainder, quotient} (DIV)
    logic [ACC_W-1:0]   r_opd;    // multiplicand or divisor
    logic [ACC_W-1:0]   r_acc;
    logic               r_first;
    logic               r_btn_q;
    logic               r_busy;
    logic               r_done;
    logic               r_ovf;
    logic               r_div0;

    logic               w_start;
    logic [ACC_W-1:0]   w_a;
    logic [ACC_W-1:0]   w_b;
    logic [ACC_W-1:0]   w_sq;
    logic [ACC_W:0]     w_add;
    logic [ACC_W-1:0]   w_sub;
    logic [ACC_W:0]     w_mul_sum;
    logic [2*ACC_W-1:0] w_mul_next;
    logic [ACC_W:0]     w_div_top;
    logic               w_div_ge;
    logic [ACC_W-1:0]   w_div_rem;
    logic [2*ACC_W-1:0] w_div_next;
    logic [2*ACC_W-1:0] w_step;

    assign w_start = bus.button & ~r_btn_q & (r_state == S_IDLE);
    assign w_a     = r_first ? r_acc : ACC_W'(bus.num1);
    assign w_b     = ACC_W'(bus.num2);
    // Square uses num2 on the first op and the accumulator when chained.
    assign w_sq    = r_first ? r_acc : w_b;
    assign w_add   = {1'b0, w_a} + {1'b0, w_b};
    assign w_sub   = w_a - w_b;

    // Shift-add multiply step: conditionally add into the upper half, then
    // shift the whole product right; the multiplier drains out of the LSBs.
    assign w_mul_sum  = {1'b0, r_pq[2*ACC_W-1:ACC_W]} + (r_pq[0] ? {1'b0, r_opd} : '0);
    assign w_mul_next = {w_mul_sum, r_pq[ACC_W-1:1]};

    // Restoring divide step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift the quotient bit in at LSB.
    // The shifted remainder is < 2*divisor, so ACC_W+1 bits suffice and the
    // restored difference always fits in ACC_W bits.
    assign w_div_top  = r_pq[2*ACC_W-1:ACC_W-1];
    assign w_div_ge   = (w_div_top >= {1'b0, r_opd});
    assign w_div_rem  = w_div_top[ACC_W-1:0] - r_opd;
    assign w_div_next = {(w_div_ge ? w_div_rem : w_div_top[ACC_W-1:0]),
                         r_pq[ACC_W-2:0], w_div_ge};

    assign w_step = (r_kind == K_MUL) ? w_mul_next : w_div_next;

    always_ff @(posedge clk_g or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_kind  <= K_MUL;
            r_cnt   <= '0;
            r_pq    <= '0;
            r_opd   <= '0;
            r_acc   <= '0;
            r_first <= 1'b0;
            r_btn_q <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_btn_q <= bus.button;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_ovf  <= 1'b0;
                        r_div0 <= 1'b0;
                        case (bus.func)
                            c_OP_ADD: begin
                                r_acc   <= w_add[ACC_W-1:0];
                                r_ovf   <= w_add[ACC_W];
                                r_first <= 1'b1;
                                r_done  <= 1'b1;
                            end
                            c_OP_SUB: begin
                                r_acc   <= w_sub;
                                r_ovf   <= (w_a < w_b);
                                r_first <= 1'b1;
                                r_done  <= 1'b1;
                            end
                            c_OP_MUL, c_OP_SQR: begin
                                r_kind  <= K_MUL;
                                r_pq    <= {{ACC_W{1'b0}}, (bus.func == c_OP_SQR) ? w_sq : w_a};
                                r_opd   <= (bus.func == c_OP_SQR) ? w_sq : w_b;
                                r_cnt   <= '0;
                                r_busy  <= 1'b1;
                                r_state <= S_ITER;
                            end
                            c_OP_DIV, c_OP_MOD: begin
                                if (w_b == '0) begin
                                    r_div0 <= 1'b1;
                                    r_done <= 1'b1;
                                end else begin
                                    r_kind  <= (bus.func == c_OP_DIV) ? K_DIV : K_MOD;
                                    r_pq    <= {{ACC_W{1'b0}}, w_a};
                                    r_opd   <= w_b;
                                    r_cnt   <= '0;
                                    r_busy  <= 1'b1;
                                    r_state <= S_ITER;
                                end
                            end
                            c_OP_CLR: begin
                                r_acc   <= '0;
                                r_first <= 1'b0;
                                r_done  <= 1'b1;
                            end
                            default: begin
                                r_done <= 1'b1;
                            end
                        endcase
                    end
                end
                S_ITER: begin
                    r_pq  <= w_step;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(ACC_W - 1)) begin
                        r_state <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    case (r_kind)
                        K_MUL: begin
                            r_acc <= r_pq[ACC_W-1:0];
                            r_ovf <= |r_pq[2*ACC_W-1:ACC_W];
                        end
                        K_DIV:   r_acc <= r_pq[ACC_W-1:0];
                        default: r_acc <= r_pq[2*ACC_W-1:ACC_W];
                    endcase
                    r_first <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cal_result = r_acc;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.ovf        = r_ovf;
    assign bus.err_div0   = r_div0;
endmodule
`default_nettype wire

// File: tb/tb_calc_acc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc_acc_seq
// Description : Self-checking bench for calc_acc_seq (DATA_W=8, ACC_W=32).
//               Chained table of operations with hand-computed results, plus
//               held/repeated button and mid-operation reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_acc_seq;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 32;
    localparam int N_VEC  = 26;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    calc_acc_seq_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

    calc_acc_seq #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk_g (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [7:0]  n1;
        logic [7:0]  n2;
        logic [31:0] res;
        logic        ovf;
        logic        dz;
        int          bc;
    } vec_t;

    vec_t vecs [N_VEC];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Press once, scramble inputs while the op runs, then check the result,
    // flags, busy length, result hold during ITER and the one-cycle done.
    task automatic run_op(input string nm, input logic [2:0] f, input logic [7:0] n1,
                          input logic [7:0] n2, input logic [31:0] exp_res,
                          input logic exp_ovf, input logic exp_dz, input int exp_bc,
                          input logic [31:0] prev_res);
        logic dn;
        logic hold_ok;
        int   bc;
        @(negedge clk);
        bus.func = f; bus.num1 = n1; bus.num2 = n2; bus.button = 1'b1;
        @(posedge clk); #1;
        dn      = bus.done;
        bc      = bus.busy ? 1 : 0;
        hold_ok = dn ? 1'b1 : (bus.cal_result === prev_res);
        @(negedge clk);
        bus.button = 1'b0; bus.func = 3'b110; bus.num1 = ~n1; bus.num2 = ~n2;
        for (int k = 0; k < 100 && !dn; k++) begin
            @(posedge clk); #1;
            if (bus.done) dn = 1'b1;
            else begin
                if (bus.busy) bc++;
                if (bus.cal_result !== prev_res) hold_ok = 1'b0;
            end
        end
        chk({nm, " done seen"}, 64'(dn), 64'(1));
        chk({nm, " result"}, 64'(bus.cal_result), 64'(exp_res));
        chk({nm, " ovf"}, 64'(bus.ovf), 64'(exp_ovf));
        chk({nm, " err_div0"}, 64'(bus.err_div0), 64'(exp_dz));
        chk({nm, " busy cycles"}, 64'(bc), 64'(exp_bc));
        chk({nm, " busy at done"}, 64'(bus.busy), 64'(0));
        if (exp_bc > 0) chk({nm, " hold during iter"}, 64'(hold_ok), 64'(1));
        @(posedge clk); #1;
        chk({nm, " done drop"}, 64'(bus.done), 64'(0));
    endtask

    initial begin
        automatic logic [31:0] prev = 32'h0;
        automatic int dones = 0;
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        bus.button = 1'b0; bus.func = 3'b000; bus.num1 = 8'h00; bus.num2 = 8'h00;

        vecs[0]  = '{3'b000, 8'h12, 8'h34, 32'h0000_0046, 1'b0, 1'b0, 0};
        vecs[1]  = '{3'b001, 8'h00, 8'h50, 32'hFFFF_FFF6, 1'b1, 1'b0, 0};
        vecs[2]  = '{3'b000, 8'h00, 8'h0A, 32'h0000_0000, 1'b1, 1'b0, 0};
        vecs[3]  = '{3'b110, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[4]  = '{3'b010, 8'hFF, 8'hFF, 32'h0000_FE01, 1'b0, 1'b0, 33};
        vecs[5]  = '{3'b110, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[6]  = '{3'b011, 8'd200, 8'd7, 32'h0000_001C, 1'b0, 1'b0, 33};
        vecs[7]  = '{3'b100, 8'h00, 8'd5, 32'h0000_0003, 1'b0, 1'b0, 33};
        vecs[8]  = '{3'b110, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[9]  = '{3'b011, 8'd200, 8'd7, 32'h0000_001C, 1'b0, 1'b0, 33};
        vecs[10] = '{3'b011, 8'h00, 8'h00, 32'h0000_001C, 1'b0, 1'b1, 0};
        vecs[11] = '{3'b000, 8'h00, 8'h01, 32'h0000_001D, 1'b0, 1'b0, 0};
        vecs[12] = '{3'b101, 8'h00, 8'h00, 32'h0000_0349, 1'b0, 1'b0, 33};
        vecs[13] = '{3'b111, 8'h00, 8'h00, 32'h0000_0349, 1'b0, 1'b0, 0};
        vecs[14] = '{3'b110, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[15] = '{3'b000, 8'hFF, 8'h01, 32'h0000_0100, 1'b0, 1'b0, 0};
        vecs[16] = '{3'b101, 8'h00, 8'h00, 32'h0001_0000, 1'b0, 1'b0, 33};
        vecs[17] = '{3'b101, 8'h00, 8'h00, 32'h0000_0000, 1'b1, 1'b0, 33};
        vecs[18] = '{3'b110, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[19] = '{3'b000, 8'h03, 8'h04, 32'h0000_0007, 1'b0, 1'b0, 0};
        vecs[20] = '{3'b110, 8'h00, 8'h00, 32'h0000_0000, 1'b0, 1'b0, 0};
        vecs[21] = '{3'b101, 8'h00, 8'h10, 32'h0000_0100, 1'b0, 1'b0, 33};
        vecs[22] = '{3'b100, 8'h00, 8'h00, 32'h0000_0100, 1'b0, 1'b1, 0};
        vecs[23] = '{3'b100, 8'h00, 8'h07, 32'h0000_0004, 1'b0, 1'b0, 33};
        vecs[24] = '{3'b001, 8'h00, 8'h05, 32'hFFFF_FFFF, 1'b1, 1'b0, 0};
        vecs[25] = '{3'b011, 8'h00, 8'h10, 32'h0FFF_FFFF, 1'b0, 1'b0, 33};

        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset cal_result", 64'(bus.cal_result), 64'(0));
        chk("reset busy", 64'(bus.busy), 64'(0));
        chk("reset done", 64'(bus.done), 64'(0));
        chk("reset ovf", 64'(bus.ovf), 64'(0));
        chk("reset err_div0", 64'(bus.err_div0), 64'(0));

        for (int i = 0; i < N_VEC; i++) begin
            run_op($sformatf("v%0d", i), vecs[i].f, vecs[i].n1, vecs[i].n2,
                   vecs[i].res, vecs[i].ovf, vecs[i].dz, vecs[i].bc, prev);
            prev = vecs[i].res;
        end

        // Held button plus an extra press while busy: exactly one multiply.
        run_op("pre-hold clear", 3'b110, 8'h00, 8'h00, 32'h0, 1'b0, 1'b0, 0, prev);
        @(negedge clk);
        bus.func = 3'b010; bus.num1 = 8'h03; bus.num2 = 8'h05;
        for (int i = 0; i < 60; i++) begin
            if (i > 0) @(negedge clk);
            bus.button = (i < 10) || (i == 15);
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        bus.button = 1'b0;
        chk("hold one done", 64'(dones), 64'(1));
        chk("hold result", 64'(bus.cal_result), 64'(32'h0000_000F));
        chk("hold idle after", 64'(bus.busy), 64'(0));

        // Reset during ITER of a chained multiply (acc=0xF, first=1).
        @(negedge clk);
        bus.func = 3'b010; bus.num2 = 8'hFF; bus.button = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        chk("mid busy before reset", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("mid reset cal_result", 64'(bus.cal_result), 64'(0));
        chk("mid reset busy", 64'(bus.busy), 64'(0));
        chk("mid reset done", 64'(bus.done), 64'(0));
        chk("mid reset ovf", 64'(bus.ovf), 64'(0));
        bus.button = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_op("post reset add", 3'b000, 8'h02, 8'h03, 32'h0000_0005, 1'b0, 1'b0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
